// File: rtl/popcount_pkg.sv
// Shared constants and types for the round-robin popcount scheduler.
// The id and count widths are tied to N_REQ and VW and are never overridden.
package popcount_pkg;

    localparam int N_REQ = 4;
    localparam int IDW   = 2;
    localparam int VW    = 16;
    localparam int CW    = 5;

    typedef logic [CW-1:0]  count_t;
    typedef logic [IDW-1:0] id_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/count_ones.sv
// Combinational ones-counter: number of set bits in a VW-wide vector.
module count_ones
    import popcount_pkg::*;
(
    input  logic [VW-1:0] vec,
    output logic [CW-1:0] count
);

    // Adder chain over all bits; the result fits in CW bits, so it cannot overflow.
    always_comb begin
        count = {CW{1'b0}};
        for (int i = 0; i < VW; i++) begin
            count = count + CW'(vec[i]);
        end
    end

endmodule

// File: rtl/popcount_rr_sched.sv
// Round-robin arbiter sharing one ones-counter between N_REQ requesters;
// the count and requester id are returned through a one-entry result register.
module popcount_rr_sched
    import popcount_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*VW-1:0]  req_vec,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 res_valid,
    output logic [IDW-1:0]       res_id,
    output logic [CW-1:0]        res_count,
    input  logic                 res_ready,
    output logic                 busy
);

    state_t              state_r;
    state_t              state_next_s;
    id_t                 rr_ptr_r;
    id_t                 grant_idx_s;
    logic                grant_found_s;
    logic                can_accept_s;
    logic                accept_s;
    logic [VW-1:0]       sel_vec_s;
    count_t              sel_count_s;
    logic                res_valid_r;
    id_t                 res_id_r;
    count_t              res_count_r;

    // Priority search starting at rr_ptr; the id arithmetic wraps modulo N_REQ.
    always_comb begin
        id_t cand_v;
        grant_found_s = 1'b0;
        grant_idx_s   = {IDW{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            cand_v = rr_ptr_r + id_t'(k);
            if (!grant_found_s && req_valid[cand_v]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_v;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Handshake terms: a held result blocks new work unless it drains this cycle.
    always_comb begin
        can_accept_s = (state_r == ST_EMPTY) || res_ready;
        accept_s     = grant_found_s && can_accept_s;
        if (accept_s) begin
            req_ready = N_REQ'(1) << grant_idx_s;
        end else begin
            req_ready = {N_REQ{1'b0}};
        end
    end

    // Only the granted slice reaches the counter, so other requesters' bits are don't-care.
    always_comb begin
        sel_vec_s = req_vec[int'(grant_idx_s) * VW +: VW];
    end

    count_ones u_count_ones (
        .vec   (sel_vec_s),
        .count (sel_count_s)
    );

    // Next-state logic for the result register occupancy.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_next_s = ST_FULL;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (res_ready && !accept_s) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: state_next_s = ST_EMPTY;
        endcase
    end

    // State, pointer and result registers; a held result is discarded on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            rr_ptr_r    <= {IDW{1'b0}};
            res_valid_r <= 1'b0;
            res_id_r    <= {IDW{1'b0}};
            res_count_r <= {CW{1'b0}};
        end else begin
            state_r     <= state_next_s;
            res_valid_r <= (state_next_s == ST_FULL);
            if (accept_s) begin
                res_id_r    <= grant_idx_s;
                res_count_r <= sel_count_s;
                rr_ptr_r    <= grant_idx_s + id_t'(1);
            end
        end
    end

    assign res_valid = res_valid_r;
    assign res_id    = res_id_r;
    assign res_count = res_count_r;
    assign busy      = (|req_valid) || res_valid_r;

endmodule

// File: tb/tb_popcount_rr_sched.sv
// Scoreboard bench for popcount_rr_sched: directed scenarios, async reset and a random soak.
module tb_popcount_rr_sched;
    import popcount_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*VW-1:0] req_vec;
    logic [N_REQ-1:0]    req_ready;
    logic                res_valid;
    logic [IDW-1:0]      res_id;
    logic [CW-1:0]       res_count;
    logic                res_ready;
    logic                busy;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [CW-1:0]  cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   m_full   = 1'b0;
    int   m_ptr    = 0;
    int   starve[N_REQ];

    popcount_rr_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_vec   (req_vec),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_count (res_count),
        .res_ready (res_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic int ref_pop(input logic [VW-1:0] v);
        int n = 0;
        for (int b = 0; b < VW; b++) begin
            if (v[b] === 1'b1) n++;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: predicts grant, handshake and occupancy; pushes expected results.
    always @(negedge clk) begin : model_blk
        int  g;
        bit  found;
        bit  can;
        logic [N_REQ-1:0] er;
        if (rst_n === 1'b1) begin
            found = 1'b0;
            g     = 0;
            for (int k = 0; k < N_REQ; k++) begin
                int c;
                c = (m_ptr + k) % N_REQ;
                if (!found && req_valid[c] === 1'b1) begin
                    found = 1'b1;
                    g     = c;
                end
            end
            can = !m_full || (res_ready === 1'b1);
            er  = (found && can) ? (N_REQ'(1) << g) : '0;
            check("req_ready", 32'(req_ready), 32'(er));
            check("res_valid", 32'(res_valid), 32'(m_full));
            check("busy", 32'(busy), 32'((|req_valid) || m_full));
            if (found && can) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (i == g || req_valid[i] !== 1'b1) starve[i] = 0;
                    else starve[i]++;
                    check("starvation", 32'(starve[i] < N_REQ), 32'd1);
                end
                sb_q.push_back({IDW'(g), CW'(ref_pop(req_vec[g*VW +: VW]))});
                m_ptr  = (g + 1) % N_REQ;
                m_full = 1'b1;
            end else if (res_ready === 1'b1) begin
                m_full = 1'b0;
            end
        end
    end

    // Monitor: the held result must match the queue head; it pops on each handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && res_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=id%0d/cnt%0d required=no result", res_id, res_count);
            end else begin
                check("res_id", 32'(res_id), 32'(sb_q[0].id));
                check("res_count", 32'(res_count), 32'(sb_q[0].cnt));
                if (res_ready === 1'b1) void'(sb_q.pop_front());
            end
        end
    end

    logic [CW-1:0] rot_cnt [N_REQ];

    initial begin
        rot_cnt[0] = 5'd0;
        rot_cnt[1] = 5'd16;
        rot_cnt[2] = 5'd1;
        rot_cnt[3] = 5'd2;
        for (int i = 0; i < N_REQ; i++) starve[i] = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_vec   = '0;
        res_ready = 1'b0;
        #1;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        check("rst_res_count", 32'(res_count), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request from requester 2, then drain to empty.
        next_cycle();
        req_vec[2*VW +: VW] = 16'hF0F0;
        req_valid = 4'b0100;
        res_ready = 1'b1;
        @(negedge clk);
        check("single_req_ready", 32'(req_ready), 32'h4);
        next_cycle();
        req_valid = 4'b0000;
        @(negedge clk);
        check("single_valid", 32'(res_valid), 32'd1);
        check("single_id", 32'(res_id), 32'd2);
        check("single_count", 32'(res_count), 32'd8);
        next_cycle();
        @(negedge clk);
        check("drain_valid", 32'(res_valid), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);

        // Hold a result with rr_ptr=3, then reset between edges.
        next_cycle();
        req_valid = 4'b0100;
        res_ready = 1'b0;
        next_cycle();
        req_valid = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(res_valid), 32'd0);
        check("async_rst_id", 32'(res_id), 32'd0);
        sb_q.delete();
        m_full = 1'b0;
        m_ptr  = 0;
        for (int i = 0; i < N_REQ; i++) starve[i] = 0;
        next_cycle();
        rst_n = 1'b1;
        req_vec   = {16'h8001, 16'h0001, 16'hFFFF, 16'h0000};
        req_valid = 4'b1111;
        res_ready = 1'b1;
        @(negedge clk);
        check("post_rst_grant", 32'(req_ready), 32'h1);

        // Rotation with everyone valid and the consumer always ready.
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            @(negedge clk);
            check("rot_valid", 32'(res_valid), 32'd1);
            check("rot_id", 32'(res_id), 32'(k % N_REQ));
            check("rot_count", 32'(res_count), 32'(rot_cnt[k % N_REQ]));
        end

        // Backpressure: requester 0's result is held while requester 1 waits.
        next_cycle();
        req_valid = 4'b0010;
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_id", 32'(res_id), 32'd0);
            check("bp_count", 32'(res_count), 32'd0);
            next_cycle();
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(req_ready), 32'h2);
        next_cycle();
        req_valid = 4'b0000;
        res_ready = 1'b0;
        @(negedge clk);
        check("bp_after_valid", 32'(res_valid), 32'd1);
        check("bp_after_id", 32'(res_id), 32'd1);
        check("bp_after_count", 32'(res_count), 32'd16);
        next_cycle();
        res_ready = 1'b1;

        // Random soak with roughly 40% ones per vector bit.
        for (int n = 0; n < 20000; n++) begin
            next_cycle();
            req_valid = N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
            res_ready = ($urandom_range(0, 3) != 0);
            for (int b = 0; b < N_REQ * VW; b++) begin
                req_vec[b] = ($urandom_range(0, 99) < 40);
            end
        end

        next_cycle();
        req_valid = '0;
        res_ready = 1'b1;
        repeat (3) next_cycle();
        check("sb_empty_at_end", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
